// File: rtl/bist_result_reporter.sv
// Captures BIST results on each done edge and serialises {start, error, signature, parity} MSB first.
// First bit is valid one cycle after the done edge; a bit is held while ser_ready is low.
module bist_result_reporter #(
    parameter  int SIG_SIZE  = 5,
    parameter  int CNT_SIZE  = 8,
    localparam int FRAME_LEN = SIG_SIZE + 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                done,
    input  logic                error,
    input  logic [SIG_SIZE-1:0] signature,
    input  logic                clear_stats,
    output logic                ser_out,
    output logic                ser_valid,
    input  logic                ser_ready,
    output logic                busy,
    output logic [CNT_SIZE-1:0] pass_count,
    output logic [CNT_SIZE-1:0] fail_count,
    output logic                overrun
);

    localparam int BW = $clog2(FRAME_LEN);
    localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_done_q;
    logic                   r_ser_valid;
    logic [FRAME_LEN-1:0]   r_shreg;
    logic [BW-1:0]          r_bitcnt;
    logic [CNT_SIZE-1:0]    r_pass;
    logic [CNT_SIZE-1:0]    r_fail;
    logic                   r_overrun;

    logic                   w_event;
    logic                   w_parity;
    logic [FRAME_LEN-1:0]   w_frame;
    logic [CNT_SIZE-1:0]    w_pass_base;
    logic [CNT_SIZE-1:0]    w_fail_base;
    logic [CNT_SIZE-1:0]    w_pass_next;
    logic [CNT_SIZE-1:0]    w_fail_next;
    logic                   w_overrun_next;

    // A done held high for many cycles still produces a single event.
    assign w_event  = done & ~r_done_q;
    assign w_parity = ^{error, signature};
    assign w_frame  = {1'b1, error, signature, w_parity};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_done_q    <= 1'b0;
            r_ser_valid <= 1'b0;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
        end else begin
            r_done_q <= done;
            case (r_state)
                IDLE: begin
                    if (w_event) begin
                        r_shreg     <= w_frame;
                        r_bitcnt    <= BW'(FRAME_LEN - 1);
                        r_ser_valid <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (ser_ready) begin
                        r_shreg  <= {r_shreg[FRAME_LEN-2:0], 1'b0};
                        r_bitcnt <= r_bitcnt - BW'(1);
                        if (r_bitcnt == '0) begin
                            r_ser_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: begin
                    r_ser_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Clear is applied first so a same-cycle event lands on the zeroed counter.
    always_comb begin
        w_pass_base    = clear_stats ? '0 : r_pass;
        w_fail_base    = clear_stats ? '0 : r_fail;
        w_pass_next    = w_pass_base;
        w_fail_next    = w_fail_base;
        w_overrun_next = clear_stats ? 1'b0 : r_overrun;
        if (w_event) begin
            if (error) begin
                if (w_fail_base != CNT_MAX) begin
                    w_fail_next = w_fail_base + CNT_SIZE'(1);
                end
            end else begin
                if (w_pass_base != CNT_MAX) begin
                    w_pass_next = w_pass_base + CNT_SIZE'(1);
                end
            end
            if (r_state == SEND && !clear_stats) begin
                w_overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pass    <= '0;
            r_fail    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pass    <= w_pass_next;
            r_fail    <= w_fail_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign ser_valid  = r_ser_valid;
    assign ser_out    = r_shreg[FRAME_LEN-1] & r_ser_valid;
    assign busy       = r_ser_valid;
    assign pass_count = r_pass;
    assign fail_count = r_fail;
    assign overrun    = r_overrun;

endmodule
